// File: rtl/dual_port_ram_be.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only.
// A clear engine fills every word with CLEAR_VALUE after reset or on request.
module dual_port_ram_be #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    RDW_MODE    = 0,
  parameter int                    OUT_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int                   NBYTES      = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  output logic                  dbg_state,
  input  logic                  a_en,
  input  logic [NBYTES-1:0]     a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_a_acc;
  logic                    w_b_acc;
  logic [DATA_WIDTH-1:0]   w_a_old;
  logic [DATA_WIDTH-1:0]   w_a_new;
  logic [DATA_WIDTH-1:0]   w_a_rd;
  logic [DATA_WIDTH-1:0]   w_b_old;

  logic                    r_a_v1;
  logic                    r_b_v1;
  logic [DATA_WIDTH-1:0]   r_a_d1;
  logic [DATA_WIDTH-1:0]   r_b_d1;

  // Ports are closed off entirely while the clear engine owns the array.
  assign w_a_acc   = a_en & ~r_busy;
  assign w_b_acc   = b_en & ~r_busy;
  assign w_a_old   = r_mem[a_addr];
  assign w_b_old   = r_mem[b_addr];
  assign busy      = r_busy;
  assign dbg_state = r_state;

  always_comb begin
    w_a_new = w_a_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (a_we[i]) w_a_new[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign w_a_rd = (RDW_MODE != 0) ? w_a_new : w_a_old;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_busy  <= 1'b1;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LAST_PTR) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          if (clear) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
          end
        end
      endcase
    end
  end

  // Array has no reset; the clear engine is what initialises it.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= CLEAR_VALUE;
    end else if (w_a_acc) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (a_we[i]) r_mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_acc;
      r_b_v1 <= w_b_acc;
      if (w_a_acc) r_a_d1 <= w_a_rd;
      if (w_b_acc) r_b_d1 <= w_b_old;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_a_v2;
      logic                  r_b_v2;
      logic [DATA_WIDTH-1:0] r_a_d2;
      logic [DATA_WIDTH-1:0] r_b_d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_d2 <= '0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) r_a_d2 <= r_a_d1;
          if (r_b_v1) r_b_d2 <= r_b_d1;
        end
      end

      assign a_valid = r_a_v2;
      assign b_valid = r_b_v2;
      assign a_dout  = r_a_d2;
      assign b_dout  = r_b_d2;
    end else begin : g_no_out_reg
      assign a_valid = r_a_v1;
      assign b_valid = r_b_v1;
      assign a_dout  = r_a_d1;
      assign b_dout  = r_b_d1;
    end
  endgenerate

endmodule
